// File: rtl/aes_decr_iter.sv
// Iterative AES-128 inverse cipher. Each clock does one round. The round keys
// are expanded combinationally from the registered cipher key. The block sits
// behind a valid/ready handshake on both the input and the output side.
module aes_decr_iter #(
    parameter bit ZERO_OUT_IDLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in,
    input  logic [127:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    state_e       st_q;
    logic [3:0]   rnd_q;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic [127:0] round_d;
    logic [127:0] rk [11];

    // ---------------------------------------------------------------------
    // GF(2^8) arithmetic, polynomial 0x11B
    // ---------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; this maps 0 to 0, which is what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Forward S-box: GF inverse followed by the affine map (used by the key schedule).
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine map followed by GF inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // ---------------------------------------------------------------------
    // Inverse round transforms. Byte k sits at bits [127-8k -: 8], and
    // byte (r + 4c) holds row r of column c.
    // ---------------------------------------------------------------------
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                o[7'(120 - 8 * (r + 4 * c)) +: 8] = s[7'(120 - 8 * (r + 4 * ((c + 4 - r) % 4))) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            o[7'(8 * k) +: 8] = inv_sbox(s[7'(8 * k) +: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[7'(120 - 32 * c) +: 8];
            a1 = s[7'(112 - 32 * c) +: 8];
            a2 = s[7'(104 - 32 * c) +: 8];
            a3 = s[7'(96 - 32 * c) +: 8];
            o[7'(120 - 32 * c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[7'(112 - 32 * c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[7'(104 - 32 * c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[7'(96 - 32 * c) +: 8]  = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Key schedule: expand the registered key into the 11 round keys K0..K10.
    always_comb begin : key_expand
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc  = 8'h01;
        tmp = '0;
        for (int unsigned i = 0; i < 44; i++) begin
            if (i < 4) begin
                w[6'(i)] = key_q[7'(96 - 32 * i) +: 32];
            end else begin
                tmp = w[6'(i - 1)];
                if (i % 4 == 0) begin
                    tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                    rc  = xtime(rc);
                end
                w[6'(i)] = w[6'(i - 4)] ^ tmp;
            end
        end
        for (int unsigned r = 0; r < 11; r++) begin
            rk[4'(r)] = {w[6'(4 * r)], w[6'(4 * r + 1)], w[6'(4 * r + 2)], w[6'(4 * r + 3)]};
        end
    end

    // Round datapath: select the operation for the current round counter.
    always_comb begin
        logic [127:0] sb;
        sb = inv_sub_bytes(inv_shift_rows(state_q));
        if (rnd_q == 4'd10) begin
            round_d = state_q ^ rk[10];
        end else if (rnd_q == 4'd0) begin
            round_d = sb ^ rk[0];
        end else begin
            round_d = inv_mix_columns(sb ^ rk[rnd_q]);
        end
    end

    // Control FSM: accepts a block, runs 11 rounds, then holds the result until the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= IDLE;
            rnd_q       <= '0;
            state_q     <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (in_valid) begin
                        key_q      <= key;
                        state_q    <= in;
                        rnd_q      <= 4'd10;
                        st_q       <= ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ROUND: begin
                    state_q <= round_d;
                    if (rnd_q == 4'd0) begin
                        st_q        <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        st_q        <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    st_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out       = (ZERO_OUT_IDLE && !out_valid_q) ? '0 : state_q;

endmodule
